// File: rtl/fb_rect_painter_pkg.sv
// fb_rect_painter_pkg: screen geometry defaults, RGB444 colours and painter state encoding
package fb_rect_painter_pkg;
  localparam int DEF_SCREEN_X = 640;
  localparam int DEF_SCREEN_Y = 480;
  localparam int DEF_AW = 19;
  localparam int DEF_DW = 12;
  localparam logic [11:0] RED = 12'hF00;
  localparam logic [11:0] GREEN = 12'h0F0;
  localparam logic [11:0] BLUE = 12'h00F;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, FIN = 2'd2} state_t;
endpackage

// File: rtl/fb_rect_painter.sv
// fb_rect_painter: streams a solid clipped rectangle into the frame-buffer write port, one pixel per clock
module fb_rect_painter
  import fb_rect_painter_pkg::*;
#(
  parameter int SCREEN_X = DEF_SCREEN_X,
  parameter int SCREEN_Y = DEF_SCREEN_Y,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [9:0]    cmd_x,
  input  logic [8:0]    cmd_y,
  input  logic [9:0]    cmd_w,
  input  logic [8:0]    cmd_h,
  input  logic [DW-1:0] cmd_color,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic          done
);
  state_t r_state, w_next;
  logic [9:0] r_x0, r_w, r_cx;
  logic [8:0] r_h, r_cy;
  logic [10:0] r_x, w_nx;
  logic [9:0] r_y, w_ny;
  logic r_px_wr, w_go, w_empty, w_row_end, w_last;
  logic [AW-1:0] w_naddr, w_start;

  function automatic logic inb(input logic [10:0] x, input logic [9:0] y);
    return x < 11'(SCREEN_X) && y < 10'(SCREEN_Y);
  endfunction

  assign cmd_ready = r_state == IDLE;
  assign busy = r_state == DRAW || r_state == FIN;
  assign done = r_state == FIN;
  assign px_wr = r_px_wr;
  assign w_go = cmd_valid && r_state == IDLE;
  assign w_empty = cmd_w == 10'd0 || cmd_h == 9'd0;
  assign w_row_end = r_cx == r_w - 10'd1;
  assign w_last = w_row_end && r_cy == r_h - 9'd1;
  assign w_nx = w_row_end ? {1'b0, r_x0} : r_x + 11'd1;
  assign w_ny = w_row_end ? r_y + 10'd1 : r_y;
  // Row end jumps back to x0 on the next line; modular arithmetic keeps in-bounds addresses exact
  assign w_naddr = w_row_end ? mem_px_addr + AW'(SCREEN_X + 1) - AW'(r_w) : mem_px_addr + AW'(1);
  assign w_start = AW'(cmd_y) * AW'(SCREEN_X) + AW'(cmd_x);

  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_go) w_next = w_empty ? FIN : DRAW;
    else if (r_state == DRAW && w_last) w_next = FIN;
    else if (r_state == FIN) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_px_wr <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      r_x0 <= '0;
      r_w <= '0;
      r_h <= '0;
      r_cx <= '0;
      r_cy <= '0;
      r_x <= '0;
      r_y <= '0;
    end else if (w_go && !w_empty) begin
      r_x0 <= cmd_x;
      r_w <= cmd_w;
      r_h <= cmd_h;
      r_cx <= '0;
      r_cy <= '0;
      r_x <= {1'b0, cmd_x};
      r_y <= {1'b0, cmd_y};
      mem_px_addr <= w_start;
      mem_px_data <= cmd_color;
      r_px_wr <= inb({1'b0, cmd_x}, {1'b0, cmd_y});
    end else if (r_state == DRAW) begin
      if (w_last) r_px_wr <= 1'b0;
      else begin
        r_cx <= w_row_end ? 10'd0 : r_cx + 10'd1;
        r_cy <= w_row_end ? r_cy + 9'd1 : r_cy;
        r_x <= w_nx;
        r_y <= w_ny;
        mem_px_addr <= w_naddr;
        r_px_wr <= inb(w_nx, w_ny);
      end
    end else r_px_wr <= 1'b0;
  end
endmodule

// File: tb/tb_fb_rect_painter.sv
// tb_fb_rect_painter: directed rectangle commands checked cycle by cycle against a multiply-based address model
module tb_fb_rect_painter;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_ready, px_wr, busy, done;
  logic [9:0] cmd_x = 0, cmd_w = 0;
  logic [8:0] cmd_y = 0, cmd_h = 0;
  logic [11:0] cmd_color = 0, mem_px_data;
  logic [18:0] mem_px_addr;
  int n_chk = 0, n_bad = 0;
  int wq[$];

  fb_rect_painter dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .px_wr(px_wr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic paint(input int x, input int y, input int w, input int h, input logic [11:0] c, input bit poke);
    int ex, ey;
    bit ewr;
    cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h); cmd_color = c; cmd_valid = 1;
    chk("ready_pre", cmd_ready, 1);
    step();
    cmd_valid = 0; cmd_x = 10'd3; cmd_y = 9'd3; cmd_w = 10'd1; cmd_h = 9'd1; cmd_color = ~c;
    for (int k = 0; k < w * h; k++) begin
      cmd_valid = poke && k < w * h - 1;
      ex = x + k % w;
      ey = y + k / w;
      ewr = ex < 640 && ey < 480;
      chk("px_wr", px_wr, ewr);
      if (ewr) begin
        chk("addr", mem_px_addr, ey * 640 + ex);
        chk("data", mem_px_data, c);
        wq.push_back(int'(mem_px_addr));
      end
      if (w * h < 100) begin
        chk("busy_draw", busy, 1);
        chk("done_draw", done, 0);
        chk("ready_draw", cmd_ready, 0);
      end
      step();
    end
    cmd_valid = 0;
    chk("done_fin", done, 1);
    chk("busy_fin", busy, 1);
    chk("ready_fin", cmd_ready, 0);
    chk("px_wr_fin", px_wr, 0);
    step();
    chk("ready_idle", cmd_ready, 1);
    chk("done_idle", done, 0);
    chk("busy_idle", busy, 0);
    chk("px_wr_idle", px_wr, 0);
  endtask

  initial begin
    int e1[4] = '{3210, 3211, 3850, 3851};
    int e2[2] = '{638, 639};
    bit ok;
    repeat (3) step();
    rst = 0;
    chk("rst_px_wr", px_wr, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_px_addr, 0);
    chk("rst_data", mem_px_data, 0);
    chk("rst_ready", cmd_ready, 1);
    step();

    wq.delete();
    paint(10, 5, 2, 2, 12'hF00, 0);
    chk("t1_count", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) chk("t1_addr", wq[i], e1[i]);

    wq.delete();
    paint(638, 0, 4, 1, 12'h0F0, 0);
    chk("t2_count", wq.size(), 2);
    for (int i = 0; i < 2 && i < wq.size(); i++) chk("t2_addr", wq[i], e2[i]);

    wq.delete();
    paint(20, 20, 0, 7, 12'h00F, 0);
    chk("t3_count", wq.size(), 0);
    chk("t3_data_held", mem_px_data, 12'h0F0);

    wq.delete();
    paint(100, 200, 3, 2, 12'h00F, 1);
    chk("t4_count", wq.size(), 6);

    wq.delete();
    paint(5, 478, 3, 3, 12'hABC, 0);
    chk("ty_count", wq.size(), 6);
    wq.delete();
    paint(1023, 511, 1, 1, 12'h123, 0);
    chk("tc_count", wq.size(), 0);

    cmd_x = 10'd100; cmd_y = 9'd100; cmd_w = 10'd4; cmd_h = 9'd4; cmd_color = 12'h555; cmd_valid = 1;
    step();
    cmd_valid = 0;
    chk("t5_p0", px_wr, 1);
    chk("t5_p0_addr", mem_px_addr, 100 * 640 + 100);
    step();
    chk("t5_p1", px_wr, 1);
    step();
    chk("t5_p2", px_wr, 1);
    chk("t5_p2_addr", mem_px_addr, 100 * 640 + 102);
    rst = 1; cmd_valid = 1; cmd_w = 10'd2; cmd_h = 9'd2;
    step();
    rst = 0; cmd_valid = 0;
    chk("t5_px_wr", px_wr, 0);
    chk("t5_done", done, 0);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_busy", busy, 0);
    ok = 1;
    for (int i = 0; i < 6; i++) begin
      if (px_wr || done || busy) ok = 0;
      step();
    end
    chk("t5_quiet", ok, 1);

    wq.delete();
    paint(0, 0, 640, 50, 12'h000, 0);
    chk("t6_count", wq.size(), 32000);
    ok = 1;
    foreach (wq[i]) if (wq[i] != i) ok = 0;
    chk("t6_contig", ok, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
